// File: rtl/riscv_pkg.sv
// Shared fetch front-end definitions: sequencer states and PC constants.
`timescale 1ns/1ps
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam int          INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word-align a target; low bits of a misaligned redirect are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem
// requests, holds the fetched word for decode and applies redirects.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | request presented at pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid
// HOLD  | instruction presented to decode until inst_ready
// DROP  | in-flight response is stale (redirected), discard it
`timescale 1ns/1ps
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_inst_valid;
    logic [31:0]  r_inst_data;
    logic [31:0]  r_inst_pc;
    logic         r_fault;

    logic [31:0]  w_pc_next_seq;
    logic [31:0]  w_redirect_pc;
    logic         w_req_hs;

    assign w_pc_next_seq = r_pc + 32'(INST_BYTES);
    assign w_redirect_pc = align_pc(redirect_pc);
    assign w_req_hs      = (r_state == REQ) && imem_req_ready;

    // Request side is a pure decode of registered state and pc.
    assign imem_req_valid = (r_state == REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst_data      = r_inst_data;
    assign inst_pc        = r_inst_pc;
    assign fetch_fault    = r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst_data  <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_fault      <= 1'b0;
        end else begin
            r_fault <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_pc         <= w_redirect_pc;
                r_inst_valid <= 1'b0;
                // Decide whether a response for the old pc is still in flight.
                case (r_state)
                    REQ:     r_state <= w_req_hs ? DROP : REQ;
                    WAIT:    r_state <= imem_rsp_valid ? REQ : DROP;
                    DROP:    r_state <= imem_rsp_valid ? REQ : DROP;
                    default: r_state <= REQ;
                endcase
            end else begin
                case (r_state)
                    IDLE: r_state <= REQ;
                    REQ: begin
                        if (w_req_hs) r_state <= WAIT;
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            r_inst_data  <= imem_rsp_data;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= w_pc_next_seq;
                            r_state      <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (r_inst_valid && inst_ready) begin
                            r_inst_valid <= 1'b0;
                            r_state      <= REQ;
                        end
                    end
                    DROP: begin
                        if (imem_rsp_valid) r_state <= REQ;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: scoreboarded imem requests and decode handoffs
// against a budgeted, fixed-latency instruction memory model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    int          budget;
    int          mem_lat;
    logic        force_rsp;
    int          pcnt;
    logic [31:0] pend_addr;
    logic        m_hs;
    logic [31:0] m_addr;

    logic [31:0] req_q[$];
    logic [31:0] inst_q[$];
    time         hs_t[$];

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_req_ready = (budget > 0);

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_valid"},  32'(imem_req_valid), 32'h0);
        chk({tag, "_req_addr"},   imem_req_addr,      32'h0);
        chk({tag, "_inst_valid"}, 32'(inst_valid),     32'h0);
        chk({tag, "_inst_data"},  inst_data,          32'h0);
        chk({tag, "_inst_pc"},    inst_pc,            32'h0);
        chk({tag, "_fault"},      32'(fetch_fault),    32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((req_q.size() != 0 || inst_q.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        if (req_q.size() != 0 || inst_q.size() != 0)
            chk("drain_timeout", 32'(req_q.size() + inst_q.size()), 32'h0);
    endtask

    task automatic wait_req_low(input int max_cycles);
        int n;
        n = 0;
        while (imem_req_valid && n < max_cycles) begin
            step();
            n++;
        end
        if (imem_req_valid) chk("accept_timeout", 32'(imem_req_valid), 32'h0);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    // Memory: grants while budget remains, answers mem_lat cycles after accept.
    initial begin
        pcnt = 0;
        pend_addr = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        forever begin
            @(posedge clk);
            m_hs   = imem_req_valid && imem_req_ready;
            m_addr = imem_req_addr;
            if (m_hs) begin
                if (req_q.size() == 0) chk("req_unexpected", 32'(req_q.size()), 32'h1);
                else chk("req_addr", m_addr, req_q.pop_front());
            end
            #1;
            if (m_hs) begin
                budget--;
                pend_addr = m_addr;
                pcnt = mem_lat;
            end
            imem_rsp_valid = (pcnt == 1) || force_rsp;
            imem_rsp_data  = mem_word(pend_addr);
            force_rsp = 1'b0;
            if (pcnt > 0) pcnt--;
        end
    end

    // Decode side scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            if (rst_n && inst_valid && inst_ready) begin
                hs_t.push_back($time);
                if (inst_q.size() == 0) chk("inst_unexpected", 32'(inst_q.size()), 32'h1);
                else begin
                    e = inst_q.pop_front();
                    chk("inst_pc", inst_pc, e);
                    chk("inst_data", inst_data, mem_word(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b0;
        budget = 0;
        mem_lat = 1;
        force_rsp = 1'b0;
        repeat (2) step();
        check_reset("rst");

        // Sequential fetch, zero-wait memory, decode always ready.
        req_q.push_back(32'h0);  req_q.push_back(32'h4);  req_q.push_back(32'h8);
        inst_q.push_back(32'h0); inst_q.push_back(32'h4); inst_q.push_back(32'h8);
        inst_ready = 1'b1;
        budget = 3;
        rst_n = 1'b1;
        chk("first_req_early", 32'(imem_req_valid), 32'h0);
        step();
        chk("first_req", 32'(imem_req_valid), 32'h1);
        chk("first_addr", imem_req_addr, 32'h0);
        drain(60);
        chk("tput_count", 32'(hs_t.size()), 32'd3);
        if (hs_t.size() >= 3) begin
            chk("tput_gap1", 32'(hs_t[1] - hs_t[0]), 32'd30);
            chk("tput_gap2", 32'(hs_t[2] - hs_t[1]), 32'd30);
        end
        chk("park_addr_c", imem_req_addr, 32'hC);

        // Decode stall in HOLD.
        inst_ready = 1'b0;
        req_q.push_back(32'hC);
        inst_q.push_back(32'hC);
        budget = 1;
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        chk("hold_reached", 32'(inst_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(inst_valid), 32'h1);
            chk("hold_pc", inst_pc, 32'hC);
            chk("hold_data", inst_data, mem_word(32'hC));
            chk("hold_no_req", 32'(imem_req_valid), 32'h0);
            step();
        end
        inst_ready = 1'b1;
        drain(20);
        chk("park_addr_10", imem_req_addr, 32'h10);

        // Redirect in WAIT before the response: response dropped via DROP.
        mem_lat = 2;
        req_q.push_back(32'h10);
        budget = 1;
        wait_req_low(20);
        do_redirect(32'h100);
        chk("drop_state_req", 32'(imem_req_valid), 32'h0);
        chk("drop_addr", imem_req_addr, 32'h100);
        chk("drop_inst_valid", 32'(inst_valid), 32'h0);
        step();
        chk("drop_to_req", 32'(imem_req_valid), 32'h1);
        mem_lat = 1;
        req_q.push_back(32'h100);
        inst_q.push_back(32'h100);
        budget = 1;
        drain(20);

        // Redirect in WAIT coincident with the response: discarded, back to REQ.
        req_q.push_back(32'h104);
        budget = 1;
        wait_req_low(20);
        do_redirect(32'h200);
        chk("wrsp_req", 32'(imem_req_valid), 32'h1);
        chk("wrsp_addr", imem_req_addr, 32'h200);
        chk("wrsp_inst_valid", 32'(inst_valid), 32'h0);
        req_q.push_back(32'h200);
        inst_q.push_back(32'h200);
        budget = 1;
        drain(20);
        chk("park_addr_204", imem_req_addr, 32'h204);

        // Misaligned redirect while a request is stalled.
        do_redirect(32'h102);
        chk("mis_fault", 32'(fetch_fault), 32'h1);
        chk("mis_addr", imem_req_addr, 32'h100);
        chk("mis_req", 32'(imem_req_valid), 32'h1);
        step();
        chk("mis_fault_pulse", 32'(fetch_fault), 32'h0);
        req_q.push_back(32'h100);
        inst_q.push_back(32'h100);
        budget = 1;
        drain(20);

        // PC wrap at top of address space.
        do_redirect(32'hFFFF_FFFC);
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_fault0", 32'(fetch_fault), 32'h0);
        req_q.push_back(32'hFFFF_FFFC); req_q.push_back(32'h0);
        inst_q.push_back(32'hFFFF_FFFC); inst_q.push_back(32'h0);
        budget = 2;
        drain(30);
        chk("wrap_next", imem_req_addr, 32'h4);
        chk("wrap_fault1", 32'(fetch_fault), 32'h0);

        // Asynchronous reset in WAIT, stale response after release.
        mem_lat = 2;
        req_q.push_back(32'h4);
        budget = 1;
        wait_req_low(20);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        step();
        step();
        rst_n = 1'b1;
        #1;
        force_rsp = 1'b1;
        step();
        step();
        chk("stale_inst_valid", 32'(inst_valid), 32'h0);
        chk("stale_req", 32'(imem_req_valid), 32'h1);
        chk("stale_addr", imem_req_addr, 32'h0);
        mem_lat = 1;
        req_q.push_back(32'h0);
        inst_q.push_back(32'h0);
        budget = 1;
        drain(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
